// File: rtl/menu_link_tx.sv
// rtl/menu_link_tx.sv - UART serializer sending the menu (sel, value) pair to the display board
module menu_link_tx #(
    parameter int CLKS_PER_BIT   = 5208,
    parameter int SEL_W          = 3,
    parameter int VALUE_W        = 4,
    parameter int REFRESH_CYCLES = 50000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [SEL_W-1:0]   menu_sel,
    input  logic [VALUE_W-1:0] value,
    input  logic               force_send,
    output logic               tx,
    output logic               busy,
    output logic [7:0]         frames_sent
);
    localparam int PAIR_W = SEL_W + VALUE_W;
    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0]      REFRESH_LAST = 32'(REFRESH_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        frame_byte;
    logic [PAIR_W-1:0] last_pair;
    logic              sent_valid;
    logic              pending;
    logic [31:0]       refresh_cnt;

    logic [PAIR_W-1:0] pair;
    logic              refresh_hit;
    logic              send_req;
    logic              latch;
    logic              bit_done;

    assign pair        = {menu_sel, value};
    assign refresh_hit = (REFRESH_CYCLES > 0) && (refresh_cnt == REFRESH_LAST);
    // A request arriving in the same cycle it would be recorded is served directly.
    assign send_req    = !sent_valid || (pair != last_pair) || pending || force_send || refresh_hit;
    assign latch       = (state == IDLE) && send_req;
    assign bit_done    = (bit_cnt == BIT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sent_valid  <= 1'b0;
            pending     <= 1'b0;
            last_pair   <= '0;
            refresh_cnt <= '0;
        end else begin
            if (latch) begin
                sent_valid <= 1'b1;
                last_pair  <= pair;
                pending    <= 1'b0;
            end else if (force_send || refresh_hit) begin
                pending <= 1'b1;
            end

            if ((REFRESH_CYCLES == 0) || latch || refresh_hit) begin
                refresh_cnt <= '0;
            end else begin
                refresh_cnt <= refresh_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            frame_byte  <= '0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            frames_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (latch) begin
                        frame_byte <= {1'b1, 7'(pair)};
                        bit_cnt    <= '0;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= frame_byte[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= frame_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        bit_cnt     <= '0;
                        busy        <= 1'b0;
                        frames_sent <= frames_sent + 8'd1;
                        state       <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
